// File: rtl/irq_pkg.sv
// Shared definitions for the vectored interrupt controller.
//   IRQ_ID_W     : width of a source identifier (up to 8 sources)
//   NONE_ID      : identifier reported by the priority encoder when nothing is requesting
//   irq_vec_addr : handler address of a source; the caller truncates the result to its PC width
package irq_pkg;

  localparam int IRQ_ID_W = 3;
  localparam logic [IRQ_ID_W-1:0] NONE_ID = '1;

  function automatic int unsigned irq_vec_addr(input int unsigned base,
                                               input int unsigned stride,
                                               input int unsigned idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
//   req   : request vector, bit 0 = highest priority
//   found : at least one request bit is set
//   index : index of the winning bit (NONE_ID when found = 0)
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]  req,
  output logic                found,
  output logic [IRQ_ID_W-1:0] index
);

  // Scan from lowest priority upwards so the last hit is the winner.
  always_comb begin
    found = 1'b0;
    index = NONE_ID;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        index = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Multi-source vectored interrupt controller with nested preemption.
// Ports:
//   clk, rst                synchronous active-high reset
//   irq_in, irq_mode        raw requests and per-source mode (1 = rising edge, 0 = level)
//   mask_we, mask_wdata     mask register load (1 = source enabled)
//   gie                     global enable for new takes
//   take_ok                 pipeline can accept a redirect this cycle
//   pc_next, cur_flags      context pushed on a take
//   rti_done                RTI reached writeback; pops the save stack
//   irq_trigger, irq_vector one-cycle take pulse and handler address
//   irq_id, irq_active      source in service (top of stack) and stack non-empty
//   saved_pc, saved_flags   top-of-stack context
//   ret_valid, ret_pc, ret_flags   one-cycle pop result
//   rti_err                 one-cycle pulse on RTI with an empty stack
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ    = 4,
  parameter int          PC_W       = 8,
  parameter int          FLAG_W     = 4,
  parameter int          NEST_DEPTH = 2,
  parameter int unsigned VEC_BASE   = 'hF0,
  parameter int unsigned VEC_STRIDE = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_IRQ-1:0]  irq_in,
  input  logic [NUM_IRQ-1:0]  irq_mode,
  input  logic                mask_we,
  input  logic [NUM_IRQ-1:0]  mask_wdata,
  input  logic                gie,
  input  logic                take_ok,
  input  logic [PC_W-1:0]     pc_next,
  input  logic [FLAG_W-1:0]   cur_flags,
  input  logic                rti_done,
  output logic                irq_trigger,
  output logic [PC_W-1:0]     irq_vector,
  output logic [IRQ_ID_W-1:0] irq_id,
  output logic                irq_active,
  output logic [PC_W-1:0]     saved_pc,
  output logic [FLAG_W-1:0]   saved_flags,
  output logic                ret_valid,
  output logic [PC_W-1:0]     ret_pc,
  output logic [FLAG_W-1:0]   ret_flags,
  output logic                rti_err
);

  typedef struct packed {
    logic [PC_W-1:0]     pc;
    logic [FLAG_W-1:0]   flags;
    logic [IRQ_ID_W-1:0] id;
  } irq_entry_t;

  localparam int DW    = $clog2(NEST_DEPTH + 1);
  // Stack is rounded up to a power of two so the index width matches exactly.
  localparam int IDX_W = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;
  localparam int LVL_W = IRQ_ID_W + 1;
  localparam logic [DW-1:0]    DEPTH_MAX = DW'(NEST_DEPTH);
  localparam logic [LVL_W-1:0] IDLE_LVL  = LVL_W'(NUM_IRQ);

  logic [NUM_IRQ-1:0]  mask_q;
  logic [NUM_IRQ-1:0]  pend_q;
  logic [NUM_IRQ-1:0]  prev_irq;
  logic [DW-1:0]       depth;
  irq_entry_t          stack [2**IDX_W];

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  pending;
  logic [NUM_IRQ-1:0]  eligible;
  logic [NUM_IRQ-1:0]  take_clr;
  logic                win_found;
  logic [IRQ_ID_W-1:0] win_idx;
  logic [DW-1:0]       depth_m1;
  irq_entry_t          top_entry;
  logic [LVL_W-1:0]    cur_level;
  logic                take;
  logic                pop;

  // Edge sources use the latched pending bit; level sources follow the pin directly.
  always_comb begin
    rise     = irq_in & ~prev_irq;
    pending  = (irq_mode & pend_q) | (~irq_mode & irq_in);
    eligible = pending & mask_q & {NUM_IRQ{gie}};
  end

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .req   (eligible),
    .found (win_found),
    .index (win_idx)
  );

  always_comb begin
    depth_m1   = depth - 1'b1;
    irq_active = (depth != '0);
    top_entry  = stack[depth_m1[IDX_W-1:0]];
    cur_level  = irq_active ? {1'b0, top_entry.id} : IDLE_LVL;
    // Only a strictly higher-priority source may preempt the one in service.
    take = win_found && ({1'b0, win_idx} < cur_level) && (depth < DEPTH_MAX) &&
           take_ok && !irq_trigger && !rti_done;
    pop  = rti_done && irq_active;
    for (int i = 0; i < NUM_IRQ; i++) begin
      take_clr[i] = take && (win_idx == IRQ_ID_W'(i));
    end
  end

  always_comb begin
    irq_id      = '0;
    saved_pc    = '0;
    saved_flags = '0;
    if (irq_active) begin
      irq_id      = top_entry.id;
      saved_pc    = top_entry.pc;
      saved_flags = top_entry.flags;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q      <= '1;
      pend_q      <= '0;
      prev_irq    <= '0;
      depth       <= '0;
      irq_trigger <= 1'b0;
      irq_vector  <= '0;
      ret_valid   <= 1'b0;
      ret_pc      <= '0;
      ret_flags   <= '0;
      rti_err     <= 1'b0;
      for (int i = 0; i < 2**IDX_W; i++) begin
        stack[i] <= '0;
      end
    end else begin
      prev_irq <= irq_in;
      // A new edge wins over the clear from a take in the same cycle.
      pend_q   <= (pend_q & ~take_clr) | (irq_mode & rise);
      if (mask_we) begin
        mask_q <= mask_wdata;
      end

      irq_trigger <= take;
      irq_vector  <= take ? PC_W'(irq_vec_addr(VEC_BASE, VEC_STRIDE, 32'(win_idx))) : '0;

      ret_valid <= pop;
      ret_pc    <= pop ? top_entry.pc : '0;
      ret_flags <= pop ? top_entry.flags : '0;
      rti_err   <= rti_done && !irq_active;

      // take and pop are mutually exclusive (take requires !rti_done).
      if (take) begin
        stack[depth[IDX_W-1:0]] <= '{pc: pc_next, flags: cur_flags, id: win_idx};
        depth <= depth + 1'b1;
      end else if (pop) begin
        depth <= depth_m1;
      end
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] irq_in;
  logic [3:0] irq_mode;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       gie;
  logic       take_ok;
  logic [7:0] pc_next;
  logic [3:0] cur_flags;
  logic       rti_done;
  logic       irq_trigger;
  logic [7:0] irq_vector;
  logic [2:0] irq_id;
  logic       irq_active;
  logic [7:0] saved_pc;
  logic [3:0] saved_flags;
  logic       ret_valid;
  logic [7:0] ret_pc;
  logic [3:0] ret_flags;
  logic       rti_err;

  int errors = 0;
  int checks = 0;

  irq_controller dut (
    .clk         (clk),
    .rst         (rst),
    .irq_in      (irq_in),
    .irq_mode    (irq_mode),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .gie         (gie),
    .take_ok     (take_ok),
    .pc_next     (pc_next),
    .cur_flags   (cur_flags),
    .rti_done    (rti_done),
    .irq_trigger (irq_trigger),
    .irq_vector  (irq_vector),
    .irq_id      (irq_id),
    .irq_active  (irq_active),
    .saved_pc    (saved_pc),
    .saved_flags (saved_flags),
    .ret_valid   (ret_valid),
    .ret_pc      (ret_pc),
    .ret_flags   (ret_flags),
    .rti_err     (rti_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rti;
    rti_done = 1'b1;
    tick();
    rti_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; irq_in = '0; irq_mode = 4'b1111; mask_we = 1'b0; mask_wdata = '0;
    gie = 1'b1; take_ok = 1'b1; pc_next = '0; cur_flags = '0; rti_done = 1'b0;
    tick(2);
    chk("rst_trigger", 32'(irq_trigger), 0);
    chk("rst_active", 32'(irq_active), 0);
    chk("rst_vector", 32'(irq_vector), 0);
    chk("rst_saved_pc", 32'(saved_pc), 0);
    chk("rst_ret_valid", 32'(ret_valid), 0);
    chk("rst_rti_err", 32'(rti_err), 0);
    rst = 1'b0;
    tick();

    // 1: edge on src2 -> pending next edge, trigger the edge after
    irq_in = 4'b0100; pc_next = 8'h21; cur_flags = 4'h5;
    tick();
    chk("t1_no_trig_yet", 32'(irq_trigger), 0);
    tick();
    chk("t1_trigger", 32'(irq_trigger), 1);
    chk("t1_vector", 32'(irq_vector), 32'hF4);
    chk("t1_saved_pc", 32'(saved_pc), 32'h21);
    chk("t1_saved_flags", 32'(saved_flags), 5);
    chk("t1_irq_id", 32'(irq_id), 2);
    chk("t1_active", 32'(irq_active), 1);
    tick();
    chk("t1_pulse_one", 32'(irq_trigger), 0);

    // 3: src0 preempts src2, then LIFO returns
    irq_in = 4'b0101; pc_next = 8'h40; cur_flags = 4'hA;
    tick(2);
    chk("t3_trigger", 32'(irq_trigger), 1);
    chk("t3_vector", 32'(irq_vector), 32'hF0);
    chk("t3_irq_id", 32'(irq_id), 0);
    chk("t3_saved_pc", 32'(saved_pc), 32'h40);
    tick();
    rti();
    chk("t3_ret1_valid", 32'(ret_valid), 1);
    chk("t3_ret1_pc", 32'(ret_pc), 32'h40);
    chk("t3_ret1_flags", 32'(ret_flags), 32'hA);
    chk("t3_ret1_id", 32'(irq_id), 2);
    chk("t3_ret1_top", 32'(saved_pc), 32'h21);
    tick();
    chk("t3_ret_pulse", 32'(ret_valid), 0);
    rti();
    chk("t3_ret2_valid", 32'(ret_valid), 1);
    chk("t3_ret2_pc", 32'(ret_pc), 32'h21);
    chk("t3_ret2_flags", 32'(ret_flags), 5);
    chk("t3_idle", 32'(irq_active), 0);

    // 2: src3 and src1 together -> src1 first, src3 after its RTI
    irq_in = 4'b0000;
    tick();
    irq_in = 4'b1010; pc_next = 8'h30;
    tick(2);
    chk("t2_trigger", 32'(irq_trigger), 1);
    chk("t2_vector", 32'(irq_vector), 32'hF2);
    tick(2);
    chk("t2_src3_waits", 32'(irq_trigger), 0);
    chk("t2_id_held", 32'(irq_id), 1);
    rti();
    chk("t2_ret_pc", 32'(ret_pc), 32'h30);
    chk("t2_no_take_rti", 32'(irq_trigger), 0);
    tick();
    chk("t2_src3_trig", 32'(irq_trigger), 1);
    chk("t2_src3_vec", 32'(irq_vector), 32'hF6);
    chk("t2_src3_id", 32'(irq_id), 3);
    rti();

    // 4: stack full blocks src0 until one RTI
    irq_in = 4'b0000;
    tick();
    irq_in = 4'b0100; pc_next = 8'h50;
    tick(2);
    chk("t4_src2_trig", 32'(irq_trigger), 1);
    irq_in = 4'b0110; pc_next = 8'h60;
    tick(2);
    chk("t4_src1_trig", 32'(irq_trigger), 1);
    chk("t4_src1_id", 32'(irq_id), 1);
    irq_in = 4'b0111;
    tick(3);
    chk("t4_full_block", 32'(irq_trigger), 0);
    chk("t4_full_id", 32'(irq_id), 1);
    rti();
    chk("t4_ret_pc", 32'(ret_pc), 32'h60);
    chk("t4_top_after", 32'(saved_pc), 32'h50);
    tick();
    chk("t4_src0_trig", 32'(irq_trigger), 1);
    chk("t4_src0_vec", 32'(irq_vector), 32'hF0);
    rti();
    rti();
    chk("t4_idle", 32'(irq_active), 0);

    // 5: RTI with empty stack, then take_ok gating
    rti();
    chk("t5_rti_err", 32'(rti_err), 1);
    chk("t5_no_ret", 32'(ret_valid), 0);
    tick();
    chk("t5_err_pulse", 32'(rti_err), 0);
    irq_in = 4'b0000; take_ok = 1'b0;
    tick();
    irq_in = 4'b0010;
    tick(3);
    chk("t5_take_ok_hold", 32'(irq_trigger), 0);
    take_ok = 1'b1;
    tick();
    chk("t5_take_ok_trig", 32'(irq_trigger), 1);
    chk("t5_vec", 32'(irq_vector), 32'hF2);
    rti();

    // Masked edge source stays pending and is taken once unmasked
    irq_in = 4'b0000; mask_we = 1'b1; mask_wdata = 4'b1011;
    tick();
    mask_we = 1'b0; irq_in = 4'b0100;
    tick(3);
    chk("mask_block", 32'(irq_trigger), 0);
    mask_we = 1'b1; mask_wdata = 4'b1111;
    tick();
    mask_we = 1'b0;
    tick();
    chk("mask_release", 32'(irq_trigger), 1);
    chk("mask_vec", 32'(irq_vector), 32'hF4);
    rti();

    // Level source: taken without edge delay, retaken only after its RTI
    irq_mode = 4'b0111; irq_in = 4'b1000;
    tick();
    chk("lvl_trig", 32'(irq_trigger), 1);
    chk("lvl_vec", 32'(irq_vector), 32'hF6);
    tick(2);
    chk("lvl_no_retake", 32'(irq_trigger), 0);
    rti();
    chk("lvl_ret", 32'(ret_valid), 1);
    tick();
    chk("lvl_retake", 32'(irq_trigger), 1);
    irq_in = 4'b0000;
    rti();
    irq_mode = 4'b1111;
    tick();

    // 6: reset mid-service with src3 pending
    irq_in = 4'b0100; pc_next = 8'h77;
    tick(2);
    chk("t6_trig", 32'(irq_trigger), 1);
    irq_in = 4'b1100;
    tick(2);
    rst = 1'b1; irq_in = 4'b0000;
    tick();
    chk("t6_rst_active", 32'(irq_active), 0);
    chk("t6_rst_pc", 32'(saved_pc), 0);
    chk("t6_rst_id", 32'(irq_id), 0);
    chk("t6_rst_trig", 32'(irq_trigger), 0);
    rst = 1'b0;
    tick(3);
    chk("t6_no_trig", 32'(irq_trigger), 0);
    chk("t6_still_idle", 32'(irq_active), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
